// File: rtl/subbytes_qcheck_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// subbytes_qcheck_pkg
// Shared types and GF arithmetic for the byte-serial SubBytes engine with
// quadratic concurrent error detection.
//   NBYTES_DEFAULT : bytes per AES state
//   state_t        : sequencer states
//   pipe_t         : stage0 -> stage1 pipeline register contents
//   gf16_mul       : GF(2^4) multiply, polynomial x^4 + x + 1
//   gf256_mul      : GF(2^8) multiply, AES polynomial x^8 + x^4 + x^3 + x + 1
//   sbox           : AES SubBytes (multiplicative inverse + affine map)
// -----------------------------------------------------------------------------
package subbytes_qcheck_pkg;

    localparam int NBYTES_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic [7:0] s;    // S-box output, post-injection
        logic [3:0] w;    // predicted hi*lo of the fault-free S-box output
        logic [3:0] tag;  // byte index this entry belongs to
        logic       vld;
    } pipe_t;

    function automatic logic [3:0] gf16_mul(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] r;
        logic [3:0] p;
        r = 4'h0;
        p = a;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) r = r ^ p;
            p = {p[2:0], 1'b0} ^ (p[3] ? 4'h3 : 4'h0);
        end
        return r;
    endfunction

    function automatic logic [7:0] gf256_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h00;
        p = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r = r ^ p;
            p = {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
        end
        return r;
    endfunction

    // Inverse as x^254 = x^(2+4+...+128); maps 0 to 0 as SubBytes requires.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] p;
        logic [7:0] inv;
        p   = x;
        inv = 8'h01;
        for (int k = 1; k < 8; k++) begin
            p   = gf256_mul(p, p);
            inv = gf256_mul(inv, p);
        end
        return inv
             ^ {inv[6:0], inv[7]}
             ^ {inv[5:0], inv[7:6]}
             ^ {inv[4:0], inv[7:5]}
             ^ {inv[3:0], inv[7:4]}
             ^ 8'h63;
    endfunction

endpackage

// File: rtl/subbytes_qcheck_sequencer_if.sv
// -----------------------------------------------------------------------------
// subbytes_qcheck_sequencer_if
// Handshake bus of the SubBytes sequencer.
//   flush                 : synchronous abort
//   in_valid / in_ready   : input state handshake
//   in_state              : byte i = in_state[8i+7:8i]
//   fault_idx, fault_mask : fault injection controls, sampled on accept
//   out_valid / out_ready : result handshake
//   out_state, err_map, err : S-box outputs and per-byte check results
// master = producer/consumer side, slave = the sequencer.
// -----------------------------------------------------------------------------
interface subbytes_qcheck_sequencer_if
    import subbytes_qcheck_pkg::*;
#(
    parameter int NBYTES = NBYTES_DEFAULT
);
    logic                  flush;
    logic                  in_valid;
    logic                  in_ready;
    logic [8*NBYTES-1:0]   in_state;
    logic [3:0]            fault_idx;
    logic [7:0]            fault_mask;
    logic                  out_valid;
    logic                  out_ready;
    logic [8*NBYTES-1:0]   out_state;
    logic [NBYTES-1:0]     err_map;
    logic                  err;

    modport master (
        output flush, in_valid, in_state, fault_idx, fault_mask, out_ready,
        input  in_ready, out_valid, out_state, err_map, err
    );

    modport slave (
        input  flush, in_valid, in_state, fault_idx, fault_mask, out_ready,
        output in_ready, out_valid, out_state, err_map, err
    );
endinterface

// File: rtl/subbytes_qcheck_sequencer_lane.sv
// -----------------------------------------------------------------------------
// qcheck_lane
// Stage0 combinational lane: SubBytes, fault-injection XOR and the
// fault-free predictor w = hi*lo of the true S-box output in GF(2^4).
//   b          in  : input byte
//   idx        in  : index of the byte being processed
//   fault_idx  in  : index selected for injection
//   fault_mask in  : XOR mask applied when idx == fault_idx
//   s          out : S-box output after injection
//   w          out : predicted nibble product
// -----------------------------------------------------------------------------
module qcheck_lane
    import subbytes_qcheck_pkg::*;
(
    input  logic [7:0] b,
    input  logic [3:0] idx,
    input  logic [3:0] fault_idx,
    input  logic [7:0] fault_mask,
    output logic [7:0] s,
    output logic [3:0] w
);
    logic [7:0] sb;

    assign sb = sbox(b);
    assign s  = sb ^ ((idx == fault_idx) ? fault_mask : 8'h00);
    // Prediction is taken from the clean S-box value so an injected fault
    // shows up as a disagreement in stage1.
    assign w  = gf16_mul(sb[7:4], sb[3:0]);
endmodule

// File: rtl/subbytes_qcheck_sequencer.sv
// -----------------------------------------------------------------------------
// subbytes_qcheck_sequencer
// Byte-serial SubBytes over an 8*NBYTES-bit AES state with a quadratic
// concurrent check (hi*lo of each output byte against a predicted value).
// One lane is shared across all bytes: RUN issues one byte per cycle into a
// pipe register, stage1 checks it and writes the result slot.
//   clk  in  : clock, rising edge
//   rst  in  : asynchronous active-high reset
//   bus  slave modport of subbytes_qcheck_sequencer_if (handshakes, data,
//        fault controls, results)
// Latency: accept at edge T -> out_valid visible after edge T+NBYTES+2.
// -----------------------------------------------------------------------------
module subbytes_qcheck_sequencer
    import subbytes_qcheck_pkg::*;
#(
    parameter int NBYTES   = NBYTES_DEFAULT,
    parameter bit FAULT_EN = 1'b1
)(
    input  logic                         clk,
    input  logic                         rst,
    subbytes_qcheck_sequencer_if.slave   bus
);
    localparam logic [3:0] LAST_IDX = 4'(NBYTES - 1);

    state_t              state_q, state_d;
    logic [3:0]          idx_q;
    logic [8*NBYTES-1:0] in_state_q;
    logic [3:0]          fault_idx_q;
    logic [7:0]          fault_mask_q;
    pipe_t               pipe_q;
    logic [8*NBYTES-1:0] out_state_q;
    logic [NBYTES-1:0]   err_map_q;

    logic                accept;
    logic [7:0]          mask_eff;
    logic [7:0]          lane_b;
    logic [7:0]          lane_s;
    logic [3:0]          lane_w;
    logic                chk_e;

    // flush has priority over a same-cycle accept.
    assign accept   = (state_q == IDLE) && bus.in_valid && !bus.flush;
    assign mask_eff = FAULT_EN ? fault_mask_q : 8'h00;
    assign lane_b   = in_state_q[{idx_q, 3'b000} +: 8];

    qcheck_lane u_lane (
        .b          (lane_b),
        .idx        (idx_q),
        .fault_idx  (fault_idx_q),
        .fault_mask (mask_eff),
        .s          (lane_s),
        .w          (lane_w)
    );

    // Stage1 quadratic checker. A fault confined to the low nibble while the
    // high nibble is zero leaves the product at 0 and escapes detection.
    assign chk_e = (gf16_mul(pipe_q.s[7:4], pipe_q.s[3:0]) != pipe_q.w);

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state elements use non-blocking assignments so every register
        // samples values from before the edge, independent of block order.
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        // NOTE: defaulting the next state first keeps every path assigned,
        // which prevents a latch from being inferred.
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (bus.in_valid)           state_d = RUN;
            RUN:   if (idx_q == LAST_IDX)      state_d = DRAIN;
            // DRAIN holds until the last byte has retired from the pipe.
            DRAIN: if (!pipe_q.vld)            state_d = DONE;
            DONE:  if (bus.out_ready)          state_d = IDLE;
            default:                           state_d = IDLE;
        endcase
        if (bus.flush) state_d = IDLE;
    end

    // ---------------- input capture ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_state_q   <= '0;
            fault_idx_q  <= '0;
            fault_mask_q <= '0;
        end else if (accept) begin
            in_state_q   <= bus.in_state;
            fault_idx_q  <= bus.fault_idx;
            fault_mask_q <= bus.fault_mask;
        end
    end

    // ---------------- byte index ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q <= '0;
        end else if (accept) begin
            idx_q <= '0;
        end else if (state_q == RUN && !bus.flush && idx_q != LAST_IDX) begin
            idx_q <= idx_q + 4'd1;
        end
    end

    // ---------------- stage0 -> stage1 pipe ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_q <= '0;
        end else if (bus.flush) begin
            pipe_q.vld <= 1'b0;
        end else begin
            pipe_q.s   <= lane_s;
            pipe_q.w   <= lane_w;
            pipe_q.tag <= idx_q;
            pipe_q.vld <= (state_q == RUN);
        end
    end

    // ---------------- result registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: the result bank is a plain register, not a RAM, so it takes the
        // async reset and reads back as zero after reset.
        if (rst) begin
            out_state_q <= '0;
            err_map_q   <= '0;
        end else if (accept) begin
            err_map_q   <= '0;
        end else if (pipe_q.vld && !bus.flush) begin
            out_state_q[{pipe_q.tag, 3'b000} +: 8] <= pipe_q.s;
            err_map_q[pipe_q.tag]                  <= chk_e;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.out_state = out_state_q;
    assign bus.err_map   = err_map_q;
    assign bus.err       = |err_map_q;
endmodule

// File: tb/tb_subbytes_qcheck_sequencer.sv
// -----------------------------------------------------------------------------
// tb_subbytes_qcheck_sequencer
// Directed bench for the byte-serial SubBytes engine: reset state, latency,
// fault injection detection and masking, output hold, flush and async reset.
// -----------------------------------------------------------------------------
module tb_subbytes_qcheck_sequencer;
    localparam int NBYTES = 16;

    logic clk;
    logic rst;

    subbytes_qcheck_sequencer_if #(.NBYTES(NBYTES)) bus_if ();

    subbytes_qcheck_sequencer #(.NBYTES(NBYTES), .FAULT_EN(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one accept; returns after the accepting edge.
    task automatic accept_state(input logic [127:0] st, input logic [3:0] fidx, input logic [7:0] fmask);
        bus_if.in_state   = st;
        bus_if.fault_idx  = fidx;
        bus_if.fault_mask = fmask;
        bus_if.in_valid   = 1'b1;
        step();
        bus_if.in_valid   = 1'b0;
    endtask

    // Counts edges after accept until out_valid, bounded.
    task automatic wait_done(output int cycles);
        cycles = 0;
        while (!bus_if.out_valid && cycles < 40) begin
            step();
            cycles++;
        end
    endtask

    task automatic release_out();
        bus_if.out_ready = 1'b1;
        step();
        bus_if.out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] all63;
        logic [127:0] exp_st;
        logic [127:0] st;
        int           cyc;
        int           seen;

        all63 = {16{8'h63}};

        bus_if.flush      = 1'b0;
        bus_if.in_valid   = 1'b0;
        bus_if.in_state   = '0;
        bus_if.fault_idx  = '0;
        bus_if.fault_mask = '0;
        bus_if.out_ready  = 1'b0;

        // ---------------- reset state ----------------
        rst = 1'b1;
        #1;
        check("rst_in_ready",  128'(bus_if.in_ready),  128'd1);
        check("rst_out_valid", 128'(bus_if.out_valid), 128'd0);
        check("rst_out_state", bus_if.out_state,       128'd0);
        check("rst_err_map",   128'(bus_if.err_map),   128'd0);
        check("rst_err",       128'(bus_if.err),       128'd0);
        step();
        step();
        rst = 1'b0;
        step();

        // ---------------- 1: zero state, no fault ----------------
        accept_state('0, 4'd0, 8'h00);
        check("t1_busy", 128'(bus_if.in_ready), 128'd0);
        wait_done(cyc);
        check("t1_latency",   128'(cyc),               128'd18);
        check("t1_out_state", bus_if.out_state,        all63);
        check("t1_err_map",   128'(bus_if.err_map),    128'd0);
        check("t1_err",       128'(bus_if.err),        128'd0);
        release_out();
        check("t1_idle_ready", 128'(bus_if.in_ready),  128'd1);
        check("t1_idle_valid", 128'(bus_if.out_valid), 128'd0);

        // ---------------- 2: fault on byte 5, out_ready held high ----------------
        bus_if.out_ready = 1'b1;
        accept_state('0, 4'd5, 8'h01);
        wait_done(cyc);
        exp_st = all63;
        exp_st[47:40] = 8'h62;
        check("t2_latency",   128'(cyc),            128'd18);
        check("t2_out_state", bus_if.out_state,     exp_st);
        check("t2_err_map",   128'(bus_if.err_map), 128'h0020);
        check("t2_err",       128'(bus_if.err),     128'd1);
        step();
        bus_if.out_ready = 1'b0;
        check("t2_released", 128'(bus_if.out_valid), 128'd0);

        // ---------------- 3: byte3 = 0x09 (S = 0x01) ----------------
        st = '0;
        st[31:24] = 8'h09;
        accept_state(st, 4'd3, 8'h10);
        wait_done(cyc);
        exp_st = all63;
        exp_st[31:24] = 8'h11;
        check("t3a_out_state", bus_if.out_state,     exp_st);
        check("t3a_err_map",   128'(bus_if.err_map), 128'h0008);
        release_out();

        accept_state(st, 4'd3, 8'h01);
        wait_done(cyc);
        exp_st[31:24] = 8'h00;
        check("t3b_out_state", bus_if.out_state,     exp_st);
        check("t3b_err_map",   128'(bus_if.err_map), 128'h0000);
        check("t3b_err",       128'(bus_if.err),     128'd0);
        release_out();

        // ---------------- 4: byte0 = 0x53, hold outputs ----------------
        st = '0;
        st[7:0] = 8'h53;
        accept_state(st, 4'd0, 8'h00);
        wait_done(cyc);
        exp_st = all63;
        exp_st[7:0] = 8'hED;
        check("t4_out_state", bus_if.out_state,     exp_st);
        check("t4_err_map",   128'(bus_if.err_map), 128'h0000);
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                bus_if.in_state   = {16{8'hFF}};
                bus_if.fault_idx  = 4'd0;
                bus_if.fault_mask = 8'h10;
                bus_if.in_valid   = 1'b1;
            end
            step();
            bus_if.in_valid = 1'b0;
        end
        check("t4_hold_valid", 128'(bus_if.out_valid), 128'd1);
        check("t4_hold_state", bus_if.out_state,       exp_st);
        check("t4_hold_err",   128'(bus_if.err_map),   128'h0000);
        check("t4_hold_ready", 128'(bus_if.in_ready),  128'd0);
        release_out();
        step();
        check("t4_no_latch", 128'(bus_if.in_ready), 128'd1);

        // ---------------- 5: flush at idx 7, then fresh run ----------------
        accept_state('0, 4'd0, 8'h00);
        for (int i = 0; i < 7; i++) step();
        bus_if.flush = 1'b1;
        step();
        bus_if.flush = 1'b0;
        check("t5_flush_ready", 128'(bus_if.in_ready),  128'd1);
        check("t5_flush_valid", 128'(bus_if.out_valid), 128'd0);
        seen = 0;
        for (int i = 0; i < 25; i++) begin
            step();
            if (bus_if.out_valid) seen++;
        end
        check("t5_never_valid", 128'(seen), 128'd0);

        // flush with a same-cycle accept: accept must lose
        bus_if.flush = 1'b1;
        accept_state('0, 4'd0, 8'h00);
        bus_if.flush = 1'b0;
        check("t5_flush_accept", 128'(bus_if.in_ready), 128'd1);

        st = '0;
        st[7:0]   = 8'h53;
        st[31:24] = 8'h09;
        accept_state(st, 4'd15, 8'h10);
        wait_done(cyc);
        exp_st = all63;
        exp_st[7:0]     = 8'hED;
        exp_st[31:24]   = 8'h01;
        exp_st[127:120] = 8'h73;
        check("t5_latency",   128'(cyc),            128'd18);
        check("t5_out_state", bus_if.out_state,     exp_st);
        check("t5_err_map",   128'(bus_if.err_map), 128'h8000);
        release_out();

        // ---------------- 6: async reset in DRAIN ----------------
        accept_state('0, 4'd0, 8'h10);
        for (int i = 0; i < 16; i++) step();
        check("t6_pre_err",   128'(bus_if.err),       128'd1);
        check("t6_pre_valid", 128'(bus_if.out_valid), 128'd0);
        rst = 1'b1;
        #2;
        check("t6_rst_ready", 128'(bus_if.in_ready),  128'd1);
        check("t6_rst_valid", 128'(bus_if.out_valid), 128'd0);
        check("t6_rst_err",   128'(bus_if.err),       128'd0);
        check("t6_rst_state", bus_if.out_state,       128'd0);
        step();
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (bus_if.out_valid) seen++;
        end
        check("t6_no_partial", 128'(seen), 128'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
